// File: rtl/raster_frame_capture.sv
// Purpose: rebuild WIDTH x HEIGHT raster frames into a double buffer and expose the last finished frame.
// Latency: read port 1 cycle; frame_done is high for the cycle after the last pixel is written.
// Backpressure: none; in_valid may gap for any number of cycles and every valid beat is consumed.
module raster_frame_capture #(
   parameter int WIDTH    = 8,
   parameter int HEIGHT   = 8,
   parameter int PIX_BITS = 4,
   parameter int CNT_BITS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [PIX_BITS-1:0]        pixel_data,
   input  logic                       frame_sync,
   input  logic [$clog2(WIDTH)-1:0]   rd_x,
   input  logic [$clog2(HEIGHT)-1:0]  rd_y,
   output logic [PIX_BITS-1:0]        rd_data,
   output logic                       frame_done,
   output logic [CNT_BITS-1:0]        frame_count,
   output logic                       capturing,
   output logic                       err_short,
   input  logic                       err_clr
);

   localparam int NPIX     = WIDTH * HEIGHT;
   localparam int IDX_BITS = $clog2(NPIX);

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_BITS-1:0]   idx_q, idx_d;
   logic                  disp_sel_q;
   logic                  frame_done_q;
   logic [CNT_BITS-1:0]   frame_count_q;
   logic                  err_short_q;
   logic [PIX_BITS-1:0]   rd_data_q;

   // Two frame buffers; the one selected by disp_sel_q is display, the other is capture.
   logic [PIX_BITS-1:0]   mem_q [2][NPIX];

   logic                  wr_en;
   logic [IDX_BITS-1:0]   wr_addr;
   logic                  swap;
   logic                  err_set;
   logic                  cap_sel;
   logic [IDX_BITS-1:0]   rd_addr;

   assign cap_sel = ~disp_sel_q;
   assign rd_addr = IDX_BITS'(rd_y) * IDX_BITS'(WIDTH) + IDX_BITS'(rd_x);

   // Next-state: sync starts (or restarts) a frame, last pixel swaps buffers and returns to IDLE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      wr_addr = idx_q;
      swap    = 1'b0;
      err_set = 1'b0;
      if (in_valid) begin
         case (state_q)
            IDLE: begin
               if (frame_sync) begin
                  wr_en   = 1'b1;
                  wr_addr = '0;
                  idx_d   = IDX_BITS'(1);
                  state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               wr_en = 1'b1;
               if (frame_sync) begin
                  // Early sync abandons the partial frame, even on the final index.
                  wr_addr = '0;
                  idx_d   = IDX_BITS'(1);
                  err_set = 1'b1;
               end else if (idx_q == IDX_BITS'(NPIX - 1)) begin
                  swap    = 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_BITS'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, index, buffer select, counters and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         disp_sel_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         err_short_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         frame_done_q <= swap;
         if (swap) begin
            disp_sel_q    <= ~disp_sel_q;
            frame_count_q <= frame_count_q + CNT_BITS'(1);
         end
         if (err_set) begin
            err_short_q <= 1'b1;
         end else if (err_clr) begin
            err_short_q <= 1'b0;
         end
      end
   end

   // Framebuffer: only the capture side is ever written, so display reads stay coherent.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < NPIX; a++) begin
               mem_q[b][a] <= '0;
            end
         end
      end else if (wr_en) begin
         mem_q[cap_sel][wr_addr] <= pixel_data;
      end
   end

   // Registered read from the display buffer using the select in effect before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[disp_sel_q][rd_addr];
      end
   end

   assign rd_data     = rd_data_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign capturing   = (state_q == CAPTURE);
   assign err_short   = err_short_q;

endmodule

// File: tb/tb_raster_frame_capture.sv
// Directed bench for raster_frame_capture: read-back tables plus hand-written frame sequences.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
module tb_raster_frame_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] pixel_data;
   logic       frame_sync;
   logic [2:0] rd_x;
   logic [2:0] rd_y;
   logic [3:0] rd_data;
   logic       frame_done;
   logic [7:0] frame_count;
   logic       capturing;
   logic       err_short;
   logic       err_clr;

   raster_frame_capture #(
      .WIDTH(8), .HEIGHT(8), .PIX_BITS(4), .CNT_BITS(8)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_data(pixel_data),
      .frame_sync(frame_sync), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
      .frame_done(frame_done), .frame_count(frame_count), .capturing(capturing),
      .err_short(err_short), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   // Count every cycle frame_done is seen high.
   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
   end

   typedef struct {
      int x;
      int y;
      int exp;
   } rd_vec_t;

   // Reads of a frame with pixel i = i mod 16.
   rd_vec_t tbl [8];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] p, input logic s);
      in_valid   = 1'b1;
      pixel_data = p;
      frame_sync = s;
      step();
      in_valid   = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic rd(input int x, input int y, output int d);
      rd_x = 3'(x);
      rd_y = 3'(y);
      step();
      d = int'(rd_data);
   endtask

   // kind 0..15: constant value; 16: pattern A (i mod 16); 17: pattern B (15 - i mod 16)
   function automatic logic [3:0] pat(input int kind, input int i);
      if (kind == 16) return 4'(i % 16);
      if (kind == 17) return 4'(15 - (i % 16));
      return 4'(kind);
   endfunction

   task automatic frame(input int kind);
      for (int i = 0; i < 64; i++) send(pat(kind, i), (i == 0));
   endtask

   task automatic run_tbl(input string tag);
      int d;
      foreach (tbl[k]) begin
         rd(tbl[k].x, tbl[k].y, d);
         chk($sformatf("%s rd(%0d,%0d)", tag, tbl[k].x, tbl[k].y), d, tbl[k].exp);
      end
   endtask

   task automatic read_all(input string tag, input int exp);
      int d;
      for (int a = 0; a < 64; a++) begin
         rd(a % 8, a / 8, d);
         chk($sformatf("%s addr %0d", tag, a), d, exp);
      end
   endtask

   initial begin
      int d0;
      int d;
      tbl[0] = '{x: 0, y: 0, exp: 0};
      tbl[1] = '{x: 3, y: 2, exp: 3};
      tbl[2] = '{x: 7, y: 7, exp: 15};
      tbl[3] = '{x: 1, y: 2, exp: 1};
      tbl[4] = '{x: 5, y: 5, exp: 13};
      tbl[5] = '{x: 0, y: 4, exp: 0};
      tbl[6] = '{x: 7, y: 0, exp: 7};
      tbl[7] = '{x: 2, y: 6, exp: 2};

      rst = 1'b1; in_valid = 1'b0; pixel_data = '0; frame_sync = 1'b0;
      rd_x = '0; rd_y = '0; err_clr = 1'b0;

      // 1. reset values
      step(); step();
      rst = 1'b0;
      chk("reset frame_count", int'(frame_count), 0);
      chk("reset err_short", int'(err_short), 0);
      chk("reset capturing", int'(capturing), 0);
      chk("reset frame_done", int'(frame_done), 0);
      read_all("reset read", 0);

      // 2. full continuous frame
      d0 = done_cnt;
      send(4'd0, 1'b1);
      chk("full capturing after sync", int'(capturing), 1);
      for (int i = 1; i < 63; i++) begin
         send(pat(16, i), 1'b0);
         chk($sformatf("full capturing px %0d", i), int'(capturing), 1);
      end
      send(pat(16, 63), 1'b0);
      chk("full frame_done", int'(frame_done), 1);
      chk("full frame_count", int'(frame_count), 1);
      chk("full capturing end", int'(capturing), 0);
      step();
      chk("full frame_done one cycle", int'(frame_done), 0);
      chk("full done pulses", done_cnt - d0, 1);
      run_tbl("full");

      // 3. gapped stream
      rst = 1'b1; step(); rst = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 64; i++) begin
         send(pat(16, i), (i == 0));
         if (i % 7 == 6) repeat (5) step();
      end
      step();
      chk("gap done pulses", done_cnt - d0, 1);
      chk("gap frame_count", int'(frame_count), 1);
      run_tbl("gap");

      // 4. early sync
      d0 = done_cnt;
      send(4'hA, 1'b1);
      repeat (10) send(4'hA, 1'b0);
      send(4'h5, 1'b1);
      chk("early err_short set", int'(err_short), 1);
      chk("early capturing", int'(capturing), 1);
      rd(3, 2, d);
      chk("early display kept", d, 3);
      chk("early no frame_done", done_cnt - d0, 0);
      for (int i = 1; i < 64; i++) send(4'h5, 1'b0);
      chk("early restart frame_done", int'(frame_done), 1);
      chk("early frame_count", int'(frame_count), 2);
      read_all("early fives", 5);
      chk("early err_short sticky", int'(err_short), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("err_clr clears", int'(err_short), 0);
      send(4'd0, 1'b1);
      send(4'd1, 1'b0);
      err_clr = 1'b1;
      send(4'd0, 1'b1);
      err_clr = 1'b0;
      chk("set beats clear", int'(err_short), 1);
      for (int i = 1; i < 64; i++) send(pat(16, i), 1'b0);
      step();
      chk("early final frame_count", int'(frame_count), 3);

      // 5. idle filtering and double buffering
      d0 = done_cnt;
      for (int i = 0; i < 20; i++) begin
         send(4'd9, 1'b0);
         chk($sformatf("idle no capture %0d", i), int'(capturing), 0);
      end
      step();
      chk("idle no frame_done", done_cnt - d0, 0);
      chk("idle frame_count", int'(frame_count), 3);
      rd_x = 3'd3; rd_y = 3'd2;
      for (int i = 0; i < 64; i++) begin
         send(pat(17, i), (i == 0));
         chk($sformatf("dbuf old frame px %0d", i), int'(rd_data), 3);
      end
      chk("dbuf frame_done", int'(frame_done), 1);
      step();
      chk("dbuf new frame", int'(rd_data), 12);
      chk("dbuf frame_count", int'(frame_count), 4);

      // 6. counter wrap and reset mid-capture
      rst = 1'b1; step(); rst = 1'b0;
      d0 = done_cnt;
      for (int f = 0; f < 256; f++) begin
         frame(16);
         if (f == 254) chk("wrap count 255", int'(frame_count), 255);
      end
      chk("wrap count 0", int'(frame_count), 0);
      step();
      chk("wrap done pulses", done_cnt - d0, 256);
      d0 = done_cnt;
      for (int i = 0; i < 30; i++) send(pat(16, i), (i == 0));
      in_valid = 1'b1; pixel_data = 4'd7; rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("midrst capturing", int'(capturing), 0);
      chk("midrst frame_done", int'(frame_done), 0);
      chk("midrst frame_count", int'(frame_count), 0);
      send(4'd3, 1'b0);
      chk("midrst state idle", int'(capturing), 0);
      read_all("midrst cleared", 0);
      chk("midrst no pulses", done_cnt - d0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
